// File: rtl/branch_exec_ctrl_if.sv
// Handshake and status bundle between decode, fetch and the branch
// execution controller.
interface branch_exec_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             br_valid;
    logic             br_ready;
    logic [XLEN-1:0]  br_pc;
    logic [2:0]       br_cmp_op;
    logic [XLEN-1:0]  br_imm;
    logic [XLEN-1:0]  br_rs1_val;
    logic [XLEN-1:0]  br_rs2_val;
    logic             operands_ok;
    logic             kill;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             redirect_ready;
    logic             flush;
    logic             br_done;
    logic             br_taken;
    logic             exc_illegal;
    logic             exc_misalign;
    logic [CNT_W-1:0] cnt_branches;
    logic [CNT_W-1:0] cnt_taken;

    modport master (
        output br_valid, br_pc, br_cmp_op, br_imm,
        output br_rs1_val, br_rs2_val, operands_ok, kill,
        output redirect_ready,
        input  br_ready, redirect_valid, redirect_pc, flush,
        input  br_done, br_taken, exc_illegal, exc_misalign,
        input  cnt_branches, cnt_taken
    );

    modport slave (
        input  br_valid, br_pc, br_cmp_op, br_imm,
        input  br_rs1_val, br_rs2_val, operands_ok, kill,
        input  redirect_ready,
        output br_ready, redirect_valid, redirect_pc, flush,
        output br_done, br_taken, exc_illegal, exc_misalign,
        output cnt_branches, cnt_taken
    );
endinterface

// File: rtl/branch_exec_ctrl.sv
// B-type branch sequencer: operand wait, condition evaluation,
// held PC redirect with flush, and retirement statistics.
module branch_exec_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_exec_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        WAIT_OPS,
        EVAL,
        REDIRECT
    } state_t;

    state_t           state;
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  imm_q;
    logic [XLEN-1:0]  rs1_q;
    logic [XLEN-1:0]  rs2_q;
    logic [2:0]       op_q;
    logic             rv_q;
    logic [XLEN-1:0]  rpc_q;
    logic             done_q;
    logic             taken_q;
    logic             ill_q;
    logic             mis_q;
    logic [CNT_W-1:0] cnt_br_q;
    logic [CNT_W-1:0] cnt_tk_q;

    logic             cond;
    logic             illegal;
    logic [XLEN-1:0]  target;

    assign target = pc_q + imm_q;

    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        unique case (op_q)
            3'b000:  cond = (rs1_q == rs2_q);
            3'b001:  cond = (rs1_q != rs2_q);
            3'b100:  cond = ($signed(rs1_q) <  $signed(rs2_q));
            3'b101:  cond = ($signed(rs1_q) >= $signed(rs2_q));
            3'b110:  cond = (rs1_q <  rs2_q);
            3'b111:  cond = (rs1_q >= rs2_q);
            default: illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc_q     <= '0;
            imm_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            op_q     <= '0;
            rv_q     <= 1'b0;
            rpc_q    <= '0;
            done_q   <= 1'b0;
            taken_q  <= 1'b0;
            ill_q    <= 1'b0;
            mis_q    <= 1'b0;
            cnt_br_q <= '0;
            cnt_tk_q <= '0;
        end else begin
            done_q  <= 1'b0;
            taken_q <= 1'b0;
            ill_q   <= 1'b0;
            mis_q   <= 1'b0;
            // kill overrides everything, including a same-cycle accept
            if (bus.kill) begin
                state <= IDLE;
                rv_q  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.br_valid) begin
                            pc_q  <= bus.br_pc;
                            op_q  <= bus.br_cmp_op;
                            imm_q <= bus.br_imm;
                            if (bus.operands_ok) begin
                                rs1_q <= bus.br_rs1_val;
                                rs2_q <= bus.br_rs2_val;
                                state <= EVAL;
                            end else begin
                                state <= WAIT_OPS;
                            end
                        end
                    end
                    WAIT_OPS: begin
                        if (bus.operands_ok) begin
                            rs1_q <= bus.br_rs1_val;
                            rs2_q <= bus.br_rs2_val;
                            state <= EVAL;
                        end
                    end
                    EVAL: begin
                        state <= IDLE;
                        if (illegal) begin
                            ill_q <= 1'b1;
                        end else if (!cond) begin
                            done_q   <= 1'b1;
                            cnt_br_q <= cnt_br_q + CNT_W'(1);
                        end else if (target[1:0] != 2'b00) begin
                            mis_q <= 1'b1;
                        end else begin
                            rv_q  <= 1'b1;
                            rpc_q <= target;
                            state <= REDIRECT;
                        end
                    end
                    REDIRECT: begin
                        if (bus.redirect_ready) begin
                            rv_q     <= 1'b0;
                            done_q   <= 1'b1;
                            taken_q  <= 1'b1;
                            cnt_br_q <= cnt_br_q + CNT_W'(1);
                            cnt_tk_q <= cnt_tk_q + CNT_W'(1);
                            state    <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.br_ready       = (state == IDLE);
    assign bus.redirect_valid = rv_q;
    assign bus.flush          = rv_q;
    assign bus.redirect_pc    = rpc_q;
    assign bus.br_done        = done_q;
    assign bus.br_taken       = taken_q;
    assign bus.exc_illegal    = ill_q;
    assign bus.exc_misalign   = mis_q;
    assign bus.cnt_branches   = cnt_br_q;
    assign bus.cnt_taken      = cnt_tk_q;
endmodule

// File: tb/tb_branch_exec_ctrl.sv
// Directed bench for branch_exec_ctrl with an outcome scoreboard
// filled at issue time and drained when the DUT responds.
module tb_branch_exec_ctrl;
    localparam int XLEN  = 32;
    localparam int CNT_W = 16;
    localparam int K_NT  = 0;
    localparam int K_TK  = 1;
    localparam int K_ILL = 2;
    localparam int K_MIS = 3;

    typedef struct {
        int        kind;
        logic [31:0] tgt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   exp_br;
    int   exp_tk;
    exp_t sb[$];

    branch_exec_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    branch_exec_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t predict(input logic [31:0] pc,
                                     input logic [2:0] op,
                                     input logic [31:0] imm,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        exp_t e;
        logic t;
        e.tgt = pc + imm;
        e.kind = K_NT;
        t = 1'b0;
        case (op)
            3'd0: t = (a == b);
            3'd1: t = (a != b);
            3'd4: t = ($signed(a) < $signed(b));
            3'd5: t = !($signed(a) < $signed(b));
            3'd6: t = (a < b);
            3'd7: t = !(a < b);
            default: e.kind = K_ILL;
        endcase
        if (e.kind != K_ILL && t)
            e.kind = (e.tgt[1:0] != 2'b00) ? K_MIS : K_TK;
        return e;
    endfunction

    task automatic chk_counters(input string tag);
        chk({tag, "_cnt_br"}, bus.cnt_branches, exp_br[CNT_W-1:0]);
        chk({tag, "_cnt_tk"}, bus.cnt_taken, exp_tk[CNT_W-1:0]);
    endtask

    // Called at a negedge with the DUT idle; operands are only valid on
    // the operands_ok cycle, garbage is driven before and after it.
    task automatic issue(input logic [31:0] pc, input logic [2:0] op,
                         input logic [31:0] imm, input logic [31:0] a,
                         input logic [31:0] b, input int d);
        chk("ready_idle", bus.br_ready, 1);
        bus.br_valid    = 1'b1;
        bus.br_pc       = pc;
        bus.br_cmp_op   = op;
        bus.br_imm      = imm;
        bus.operands_ok = (d == 0);
        bus.br_rs1_val  = (d == 0) ? a : ~a;
        bus.br_rs2_val  = (d == 0) ? b : b + 32'd1;
        sb.push_back(predict(pc, op, imm, a, b));
        for (int i = 1; i <= d; i++) begin
            @(negedge clk);
            bus.br_valid    = 1'b0;
            bus.br_pc       = 32'hDEAD_0000;
            chk("ready_wait", bus.br_ready, 0);
            bus.operands_ok = (i == d);
            bus.br_rs1_val  = (i == d) ? a : ~a;
            bus.br_rs2_val  = (i == d) ? b : b + 32'd1;
        end
        @(negedge clk);
        bus.br_valid    = 1'b0;
        bus.operands_ok = 1'b0;
        bus.br_rs1_val  = 32'h1234_5678;
        bus.br_rs2_val  = 32'h8765_4321;
        chk("ready_eval", bus.br_ready, 0);
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.br_done | bus.exc_illegal | bus.exc_misalign |
                     bus.redirect_valid) && n < 20);
        chk({tag, "_latency"}, n, 1);
    endtask

    task automatic finish_branch(input string tag, input int hold);
        exp_t e;
        logic [31:0] pc0;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_illegal"}, bus.exc_illegal, e.kind == K_ILL);
        chk({tag, "_misalign"}, bus.exc_misalign, e.kind == K_MIS);
        chk({tag, "_done"}, bus.br_done, e.kind == K_NT);
        chk({tag, "_rv"}, bus.redirect_valid, e.kind == K_TK);
        if (e.kind == K_NT) begin
            chk({tag, "_taken"}, bus.br_taken, 0);
            exp_br++;
        end
        if (e.kind == K_TK) begin
            chk({tag, "_rpc"}, bus.redirect_pc, e.tgt);
            chk({tag, "_flush"}, bus.flush, 1);
            pc0 = bus.redirect_pc;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk({tag, "_hold_rv"}, bus.redirect_valid, 1);
                chk({tag, "_hold_rpc"}, bus.redirect_pc, pc0);
                chk({tag, "_hold_done"}, bus.br_done, 0);
            end
            bus.redirect_ready = 1'b1;
            @(negedge clk);
            bus.redirect_ready = 1'b0;
            chk({tag, "_acc_done"}, bus.br_done, 1);
            chk({tag, "_acc_taken"}, bus.br_taken, 1);
            chk({tag, "_acc_rv"}, bus.redirect_valid, 0);
            exp_br++;
            exp_tk++;
        end
        @(negedge clk);
        chk({tag, "_pulse_end"}, {bus.br_done, bus.exc_illegal,
                                  bus.exc_misalign, bus.flush}, 0);
        chk({tag, "_ready_back"}, bus.br_ready, 1);
        chk_counters(tag);
    endtask

    task automatic run(input string tag, input logic [31:0] pc,
                       input logic [2:0] op, input logic [31:0] imm,
                       input logic [31:0] a, input logic [31:0] b,
                       input int d, input int hold);
        issue(pc, op, imm, a, b, d);
        wait_out(tag);
        finish_branch(tag, hold);
    endtask

    initial begin
        exp_t e;
        n_vec = 0;
        n_err = 0;
        exp_br = 0;
        exp_tk = 0;
        rst_n = 1'b0;
        bus.br_valid = 1'b0;
        bus.br_pc = '0;
        bus.br_cmp_op = '0;
        bus.br_imm = '0;
        bus.br_rs1_val = '0;
        bus.br_rs2_val = '0;
        bus.operands_ok = 1'b0;
        bus.kill = 1'b0;
        bus.redirect_ready = 1'b0;

        #12;
        chk("rst_ready", bus.br_ready, 1);
        chk("rst_outs", {bus.redirect_valid, bus.flush, bus.br_done,
                         bus.br_taken, bus.exc_illegal,
                         bus.exc_misalign}, 0);
        chk("rst_rpc", bus.redirect_pc, 0);
        chk_counters("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run("beq", 32'h100, 3'b000, 32'h20, 32'd5, 32'd5, 0, 0);
        chk("beq_cnt_taken_1", bus.cnt_taken, 1);
        run("blt", 32'h200, 3'b100, 32'h40, 32'hFFFF_FFFF, 32'd1, 0, 1);
        run("bltu", 32'h200, 3'b110, 32'h40, 32'hFFFF_FFFF, 32'd1, 0, 0);
        run("bgeu", 32'h300, 3'b111, 32'hFFFF_FFF0, 32'hFFFF_FFFF,
            32'd1, 0, 2);
        chk("bgeu_cnt_br_4", bus.cnt_branches, 4);
        run("bne_nt", 32'h40, 3'b001, 32'h8, 32'd9, 32'd9, 0, 0);
        run("bge_nt", 32'h40, 3'b101, 32'h8, 32'hFFFF_FFFB, 32'd3, 0, 0);
        run("hazard", 32'h500, 3'b000, 32'h10, 32'd7, 32'd7, 3, 0);
        run("illegal2", 32'h100, 3'b010, 32'h20, 32'd1, 32'd1, 0, 0);
        run("illegal3", 32'h100, 3'b011, 32'h20, 32'd1, 32'd1, 1, 0);
        run("misalign", 32'h100, 3'b000, 32'h6, 32'd4, 32'd4, 0, 0);
        run("wrap", 32'hFFFF_FFF0, 3'b000, 32'h10, 32'd0, 32'd0, 0, 3);

        // backpressure then kill in the third redirect cycle
        issue(32'h400, 3'b000, 32'h8, 32'd7, 32'd7, 0);
        wait_out("bpkill");
        e = sb.pop_front();
        chk("bpkill_rpc", bus.redirect_pc, e.tgt);
        @(negedge clk);
        chk("bpkill_c2_rpc", bus.redirect_pc, 32'h408);
        @(negedge clk);
        chk("bpkill_c3_rv", bus.redirect_valid, 1);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        chk("bpkill_outs", {bus.redirect_valid, bus.flush,
                            bus.br_done, bus.br_taken}, 0);
        chk("bpkill_ready", bus.br_ready, 1);
        chk_counters("bpkill");

        // kill wins over a same-cycle redirect accept
        issue(32'h600, 3'b001, 32'h4, 32'd1, 32'd2, 0);
        wait_out("killacc");
        e = sb.pop_front();
        chk("killacc_rpc", bus.redirect_pc, e.tgt);
        bus.kill = 1'b1;
        bus.redirect_ready = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        bus.redirect_ready = 1'b0;
        chk("killacc_outs", {bus.redirect_valid, bus.br_done}, 0);
        chk_counters("killacc");

        // kill with br_valid in IDLE: nothing accepted
        bus.br_valid = 1'b1;
        bus.br_cmp_op = 3'b000;
        bus.br_pc = 32'h700;
        bus.br_imm = 32'h8;
        bus.br_rs1_val = 32'd3;
        bus.br_rs2_val = 32'd3;
        bus.operands_ok = 1'b1;
        bus.kill = 1'b1;
        @(negedge clk);
        bus.br_valid = 1'b0;
        bus.operands_ok = 1'b0;
        bus.kill = 1'b0;
        chk("killidle_ready", bus.br_ready, 1);
        repeat (3) @(negedge clk);
        chk("killidle_quiet", {bus.redirect_valid, bus.br_done,
                               bus.exc_illegal, bus.exc_misalign}, 0);
        chk_counters("killidle");

        // asynchronous reset while a redirect is pending
        issue(32'h800, 3'b000, 32'h10, 32'd2, 32'd2, 0);
        wait_out("arst");
        e = sb.pop_front();
        chk("arst_rv_before", bus.redirect_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_outs", {bus.redirect_valid, bus.flush, bus.br_done,
                          bus.br_taken}, 0);
        chk("arst_rpc", bus.redirect_pc, 0);
        chk("arst_ready", bus.br_ready, 1);
        exp_br = 0;
        exp_tk = 0;
        chk_counters("arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_after_ready", bus.br_ready, 1);
        chk("arst_after_rv", bus.redirect_valid, 0);
        run("post_rst", 32'h900, 3'b001, 32'hC, 32'd1, 32'd0, 2, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule
